// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide unit with valid/ready handshake and flush
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      f_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            flush_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [2:0]      f;
    logic            neg_q, neg_r;
    logic [XLEN-1:0] a;
    logic [2*XLEN:0] p, p_nxt;
    logic            s1, s2, n1, n2, div0, ovf, accept, ge;
    logic [XLEN-1:0] m1, m2, early, q, r, fin;
    logic [XLEN:0]   hi_add, dh, hi_sub;
    logic [2*XLEN-1:0] prod;
    // request decode: operand signedness, magnitudes and the single-cycle special cases
    always_comb begin
        s1     = ~(f_i[0] & (f_i[1] | f_i[2]));
        s2     = s1 & (f_i != 3'd2);
        n1     = s1 & op1_i[XLEN-1];
        n2     = s2 & op2_i[XLEN-1];
        m1     = n1 ? -op1_i : op1_i;
        m2     = n2 ? -op2_i : op2_i;
        div0   = f_i[2] & (op2_i == '0);
        ovf    = f_i[2] & ~f_i[0] & (op1_i == {1'b1, {(XLEN-1){1'b0}}}) & (&op2_i);
        early  = div0 ? (f_i[1] ? op1_i : '1) : (f_i[1] ? '0 : op1_i);
        accept = valid_i & ready_o & ~flush_i;
    end
    // one shift-add or restoring-divide step on p, plus the sign-corrected final result
    always_comb begin
        hi_add = p[0] ? p[2*XLEN:XLEN] + {1'b0, a} : p[2*XLEN:XLEN];
        dh     = p[2*XLEN-1:XLEN-1];
        ge     = dh >= {1'b0, a};
        hi_sub = dh - {1'b0, a};
        p_nxt  = f[2] ? {ge ? hi_sub : dh, p[XLEN-2:0], ge} : {1'b0, hi_add, p[XLEN-1:1]};
        prod   = neg_q ? -p_nxt[2*XLEN-1:0] : p_nxt[2*XLEN-1:0];
        q      = neg_q ? -p_nxt[XLEN-1:0] : p_nxt[XLEN-1:0];
        r      = neg_r ? -p_nxt[2*XLEN-1:XLEN] : p_nxt[2*XLEN-1:XLEN];
        fin    = f[2] ? (f[1] ? r : q) : (f[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end
    // control FSM with datapath registers and registered handshake/result outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= IDLE;
            cnt      <= '0;
            f        <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            a        <= '0;
            p        <= '0;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            result_o <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    f       <= f_i;
                    neg_q   <= n1 ^ n2;
                    neg_r   <= n1;
                    a       <= f_i[2] ? m2 : m1;
                    p       <= {{(XLEN+1){1'b0}}, f_i[2] ? m1 : m2};
                    cnt     <= '0;
                    ready_o <= 1'b0;
                    if (div0 | ovf) begin
                        state    <= DONE;
                        valid_o  <= 1'b1;
                        result_o <= early;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: if (flush_i) begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                end else begin
                    p   <= p_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN-1)) begin
                        state    <= DONE;
                        valid_o  <= 1'b1;
                        result_o <= fin;
                    end
                end
                DONE: if (flush_i | ready_i) begin
                    state    <= IDLE;
                    ready_o  <= 1'b1;
                    valid_o  <= 1'b0;
                    result_o <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized and directed checks of mul_div_unit against an arithmetic reference model
module tb_mul_div_unit;
    logic        clk = 1'b0;
    logic        rst_ni, valid_i, ready_o, flush_i, valid_o, ready_i;
    logic [2:0]  f_i;
    logic [31:0] op1_i, op2_i, result_o;
    logic        v64, rdy64, vo64, ri64, fl64;
    logic [2:0]  f64;
    logic [63:0] a64, b64, res64;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mul_div_unit #(.XLEN(32)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o), .f_i(f_i),
        .op1_i(op1_i), .op2_i(op2_i), .flush_i(flush_i), .valid_o(valid_o),
        .ready_i(ready_i), .result_o(result_o)
    );

    mul_div_unit #(.XLEN(64)) dut64 (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(v64), .ready_o(rdy64), .f_i(f64),
        .op1_i(a64), .op2_i(b64), .flush_i(fl64), .valid_o(vo64),
        .ready_i(ri64), .result_o(res64)
    );

    // reference: full-width signed/unsigned arithmetic, with the divide-by-zero rule
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'd0, 3'd1: p = 64'(sa * sb);
            3'd2:       p = 64'(sa * longint'(ub));
            3'd3:       p = ua * ub;
            3'd4:       p = (b == 0) ? '1 : 64'(sa / sb);
            3'd5:       p = (b == 0) ? '1 : ua / ub;
            3'd6:       p = (b == 0) ? ua : 64'(sa % sb);
            default:    p = (b == 0) ? ua : ua % ub;
        endcase
        return (f == 3'd1 || f == 3'd2 || f == 3'd3) ? p[63:32] : p[31:0];
    endfunction

    // rising edges after the accept edge until valid_o: 0 for the single-cycle cases
    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) ? 0 : 32;
    endfunction

    function automatic logic [31:0] rnd_op();
        case ($urandom_range(0, 6))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    task automatic start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        valid_i = 1'b1;
        f_i     = f;
        op1_i   = a;
        op2_i   = b;
        @(posedge clk); #1;
        valid_i = 1'b0;
        f_i     = 3'($urandom);
        op1_i   = $urandom;
        op2_i   = $urandom;
    endtask

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        start(f, a, b);
        lat = 0;
        while (!valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result_o;
    endtask

    task automatic consume();
        ready_i = 1'b1;
        @(posedge clk); #1;
        ready_i = 1'b0;
    endtask

    task automatic no_valid_for(input int n, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (valid_o) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        logic [31:0] res;
        int          lat;
        rst_ni = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        f_i = '0; op1_i = '0; op2_i = '0;
        v64 = 1'b0; fl64 = 1'b0; ri64 = 1'b0; f64 = '0; a64 = '0; b64 = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if ({ready_o, valid_o, result_o} !== {1'b1, 1'b0, 32'h0}) begin
            fails++;
            $display("FAIL reset_outputs: got ready=%b valid=%b result=%h, want 1 0 0", ready_o, valid_o, result_o);
        end
        rst_ni = 1'b1;
        do_op(3'd0, 32'd3, 32'd5, res, lat);
        tests++;
        if (lat !== 32) begin
            fails++;
            $display("FAIL first_accept_latency: got %0d want 32", lat);
        end
        tests++;
        if (res !== 32'd15) begin
            fails++;
            $display("FAIL first_accept_result: got %h want 0000000f", res);
        end
        consume();
    endtask

    task automatic test_directed();
        logic [2:0]  tf[12]  = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] ta[12]  = '{32'h7, 32'h7, 32'h7, 32'h7, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                 32'h1234_5678, 32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tb_[12] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd2, 32'd2,
                                 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] te[12]  = '{32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'h6, 32'h6, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                 32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'h0};
        int          tl[12]  = '{32, 32, 32, 32, 32, 32, 32, 32, 0, 0, 0, 0};
        logic [31:0] res;
        int          lat;
        for (int i = 0; i < 12; i++) begin
            do_op(tf[i], ta[i], tb_[i], res, lat);
            tests++;
            if (res !== te[i]) begin
                fails++;
                $display("FAIL directed_%0d_result: f=%0d %h,%h got %h want %h", i, tf[i], ta[i], tb_[i], res, te[i]);
            end
            tests++;
            if (lat !== tl[i]) begin
                fails++;
                $display("FAIL directed_%0d_latency: got %0d edges after accept, want %0d", i, lat, tl[i]);
            end
            consume();
            tests++;
            if ({ready_o, valid_o, result_o} !== {1'b1, 1'b0, 32'h0}) begin
                fails++;
                $display("FAIL directed_%0d_release: got ready=%b valid=%b result=%h", i, ready_o, valid_o, result_o);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, res, exp;
        int          lat, hold;
        for (int i = 0; i < 64; i++) begin
            f   = 3'(i % 8);
            a   = rnd_op();
            b   = rnd_op();
            exp = model(f, a, b);
            do_op(f, a, b, res, lat);
            tests++;
            if (res !== exp) begin
                fails++;
                $display("FAIL random_%0d_result: f=%0d %h,%h got %h want %h", i, f, a, b, res, exp);
            end
            tests++;
            if (lat !== exp_lat(f, a, b)) begin
                fails++;
                $display("FAIL random_%0d_latency: got %0d want %0d", i, lat, exp_lat(f, a, b));
            end
            hold = $urandom_range(0, 3);
            repeat (hold) @(posedge clk);
            #1;
            tests++;
            if ({valid_o, result_o} !== {1'b1, exp}) begin
                fails++;
                $display("FAIL random_%0d_hold: got valid=%b result=%h want 1 %h", i, valid_o, result_o, exp);
            end
            consume();
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b, res, exp;
        int          lat;
        logic        seen;
        a   = $urandom;
        b   = $urandom;
        exp = model(3'd1, a, b);
        do_op(3'd1, a, b, res, lat);
        tests++;
        if (res !== exp) begin
            fails++;
            $display("FAIL bp_result: got %h want %h", res, exp);
        end
        valid_i = 1'b1; f_i = 3'd0; op1_i = 32'd9; op2_i = 32'd9;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++;
            if ({valid_o, ready_o, result_o} !== {1'b1, 1'b0, exp}) begin
                fails++;
                $display("FAIL bp_stall_%0d: got valid=%b ready=%b result=%h want 1 0 %h", i, valid_o, ready_o, result_o, exp);
            end
        end
        valid_i = 1'b0;
        consume();
        tests++;
        if ({valid_o, ready_o} !== 2'b01) begin
            fails++;
            $display("FAIL bp_release: got valid=%b ready=%b want 0 1", valid_o, ready_o);
        end
        no_valid_for(40, seen);
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL bp_ignored_request: got valid_o pulse, want none");
        end
    endtask

    task automatic test_flush();
        logic [31:0] res, exp;
        int          lat;
        logic        seen;
        start(3'd5, $urandom, 32'd7 + 32'($urandom_range(0, 1000)));
        repeat (10) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        tests++;
        if ({valid_o, ready_o, result_o} !== {1'b0, 1'b1, 32'h0}) begin
            fails++;
            $display("FAIL flush_calc: got valid=%b ready=%b result=%h want 0 1 0", valid_o, ready_o, result_o);
        end
        no_valid_for(40, seen);
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL flush_calc_no_valid: got valid_o pulse, want none");
        end
        valid_i = 1'b1; flush_i = 1'b1; f_i = 3'd0; op1_i = 32'd2; op2_i = 32'd2;
        @(posedge clk); #1;
        valid_i = 1'b0; flush_i = 1'b0;
        tests++;
        if (ready_o !== 1'b1) begin
            fails++;
            $display("FAIL flush_idle_block: got ready=%b want 1", ready_o);
        end
        no_valid_for(40, seen);
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle_no_valid: got valid_o pulse, want none");
        end
        do_op(3'd0, 32'd3, 32'd5, res, lat);
        tests++;
        if (res !== 32'd15 || lat !== 32) begin
            fails++;
            $display("FAIL flush_then_mul: got %h after %0d, want 0000000f after 32", res, lat);
        end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        tests++;
        if ({valid_o, ready_o, result_o} !== {1'b0, 1'b1, 32'h0}) begin
            fails++;
            $display("FAIL flush_done: got valid=%b ready=%b result=%h want 0 1 0", valid_o, ready_o, result_o);
        end
        exp = model(3'd7, 32'd1000, 32'd0);
        do_op(3'd7, 32'd1000, 32'd0, res, lat);
        tests++;
        if (res !== exp) begin
            fails++;
            $display("FAIL flush_ready_op: got %h want %h", res, exp);
        end
        flush_i = 1'b1; ready_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0; ready_i = 1'b0;
        tests++;
        if ({valid_o, ready_o} !== 2'b01) begin
            fails++;
            $display("FAIL flush_and_ready: got valid=%b ready=%b want 0 1", valid_o, ready_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        logic        seen;
        start(3'd1, $urandom, $urandom);
        repeat (20) @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        tests++;
        if ({valid_o, ready_o, result_o} !== {1'b0, 1'b1, 32'h0}) begin
            fails++;
            $display("FAIL reset_calc: got valid=%b ready=%b result=%h want 0 1 0", valid_o, ready_o, result_o);
        end
        @(posedge clk); #1;
        rst_ni = 1'b1;
        no_valid_for(40, seen);
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL reset_calc_no_valid: got valid_o pulse, want none");
        end
        do_op(3'd5, 32'hDEAD_BEEF, 32'd0, res, lat);
        #2;
        rst_ni = 1'b0;
        #1;
        tests++;
        if ({valid_o, result_o} !== {1'b0, 32'h0}) begin
            fails++;
            $display("FAIL reset_done_async: got valid=%b result=%h want 0 0", valid_o, result_o);
        end
        @(posedge clk); #1;
        rst_ni = 1'b1;
        no_valid_for(40, seen);
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL reset_done_no_valid: got valid_o pulse, want none");
        end
    endtask

    task automatic test_xlen64();
        logic [2:0]  tf[2] = '{3'd3, 3'd0};
        logic [63:0] te[2] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h1};
        int          lat;
        for (int i = 0; i < 2; i++) begin
            v64 = 1'b1; f64 = tf[i]; a64 = '1; b64 = '1;
            @(posedge clk); #1;
            v64 = 1'b0; a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
            lat = 0;
            while (!vo64 && lat < 200) begin
                @(posedge clk); #1;
                lat++;
            end
            tests++;
            if (res64 !== te[i] || lat !== 64) begin
                fails++;
                $display("FAIL xlen64_%0d: got %h after %0d, want %h after 64", i, res64, lat, te[i]);
            end
            ri64 = 1'b1;
            @(posedge clk); #1;
            ri64 = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_xlen64();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 valid_i  input  1  request valid.
REQ-005 ready_o  output  1  unit can accept a request.
REQ-006 f_i  input  3  operation: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 op1_i  input  XLEN  first operand (multiplicand/dividend).
REQ-008 op2_i  input  XLEN  second operand (multiplier/divisor).
REQ-009 flush_i  input  1  abort the in-flight operation.
REQ-010 valid_o  output  1  result valid.
REQ-011 ready_i  input  1  consumer accepts result.
REQ-012 result_o  output  XLEN  result.

Function
REQ-013 FSM states IDLE, CALC, DONE; ready_o SHALL be 1 only in IDLE; valid_o SHALL be 1 only in DONE.
REQ-014 Acceptance = valid_i & ready_o & !flush_i at a rising edge; f_i, op1_i, op2_i SHALL be captured at that edge and not sampled again.
REQ-015 Normal operation: accept edge enters CALC with iteration counter 0; each CALC edge performs one radix-2 iteration (shift-add multiply or restoring divide on magnitudes); the edge completing iteration XLEN SHALL enter DONE, giving valid_o exactly XLEN cycles after acceptance.
REQ-016 Signed operands: MUL/MULH take both operands signed; MULHSU takes op1 signed, op2 unsigned; MULHU/DIVU/REMU take both unsigned; DIV/REM take both signed.
REQ-017 MUL SHALL return product bits [XLEN-1:0]; MULH/MULHSU/MULHU SHALL return bits [2*XLEN-1:XLEN] of the full 2*XLEN-bit product.
REQ-018 DIV/DIVU SHALL return quotient truncated toward zero; REM/REMU SHALL return remainder with sign of dividend.
REQ-019 Divide by zero (op2 = 0, f_i 4..7): quotient SHALL be all ones, remainder SHALL equal op1; the accept edge SHALL go directly to DONE (latency 1).
REQ-020 Signed overflow (DIV/REM, op1 = -2^(XLEN-1), op2 = -1): quotient SHALL equal op1, remainder SHALL be 0; latency 1 via direct entry to DONE.
REQ-021 In DONE, result_o and valid_o SHALL hold stable while ready_i = 0; edge with ready_i = 1 SHALL return to IDLE; no new request accepted in that same cycle.
REQ-022 flush_i = 1 at an edge in CALC or DONE SHALL return to IDLE and discard the result; valid_o SHALL be 0 the following cycle; flush_i in IDLE SHALL block acceptance.
REQ-023 flush_i and ready_i both 1 in DONE: SHALL return to IDLE (result considered consumed; outcome identical).
REQ-024 result_o SHALL be 0 whenever valid_o = 0.
REQ-025 Operand changes on op1_i/op2_i/f_i after acceptance SHALL not affect the result.

Reset
REQ-026 rst_ni low SHALL immediately force state IDLE, counter 0, internal operand/accumulator registers 0, ready_o = 1 (after release), valid_o = 0, result_o = 0.
REQ-027 Reset asserted mid-CALC or in DONE SHALL discard the operation; no valid_o pulse SHALL follow release.
REQ-028 First acceptance SHALL be possible at the first rising edge after rst_ni deasserts.

Verification
REQ-029 XLEN=32, MUL 0x0000_0007 x 0xFFFF_FFFD -> valid_o 32 cycles after accept, result_o 0xFFFF_FFEB; MULH same operands -> 0xFFFF_FFFF; MULHU -> 0x0000_0006.
REQ-030 DIV 0xFFFF_FFF9 (-7) / 2 -> 0xFFFF_FFFD; REM -> 0xFFFF_FFFF; DIVU 100/7 -> 14, REMU -> 2; each at 32-cycle latency.
REQ-031 DIVU 0x1234_5678 / 0 -> 0xFFFF_FFFF, REMU -> 0x1234_5678, DIV 0x8000_0000 / 0xFFFF_FFFF -> 0x8000_0000, REM -> 0, all with valid_o one cycle after accept.
REQ-032 Backpressure: hold ready_i = 0 for 5 cycles in DONE -> valid_o and result_o stable all 5 cycles, ready_o = 0, new valid_i ignored; ready_i = 1 -> IDLE next cycle.
REQ-033 flush_i at CALC iteration 10 -> IDLE next cycle, no valid_o; subsequent MUL 3 x 5 -> 15 correct.
REQ-034 rst_ni pulsed low at CALC iteration 20 -> outputs 0 asynchronously, no valid_o after release; XLEN=64 regression MULHU 0xFFFF_FFFF_FFFF_FFFF squared -> 0xFFFF_FFFF_FFFF_FFFE at 64-cycle latency.
